arb_memory: RTL and testbench

- Parametrised, synthesizable successor to the single-port mp1 memory model.
- Serves NUM_PORTS requestors, e.g. split I/D or multiple cores, over the same read/write/byte_enable/resp handshake.
- Round-robin arbitration; configurable data width, depth and response latency.
- Used in system benches and as an FPGA on-chip memory stand-in.

---
 rtl/arb_memory_pkg.sv | 24 ++
 rtl/arb_memory_if.sv | 28 ++
 rtl/arb_memory_rr_arbiter.sv | 33 +++
 rtl/arb_memory.sv | 151 +++++++++++++++
 tb/tb_arb_memory.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_memory_pkg.sv
// Shared types and width helpers for arb_memory: FSM states and byte-lane/port index sizing.
// No logic; imported by the interface users, the arbiter and the top.
package arb_memory_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

    // Address bits below the word index (byte offset within a word).
    function automatic int offset_bits(input int data_width);
        return (data_width / 8 > 1) ? $clog2(data_width / 8) : 0;
    endfunction

    function automatic int port_bits(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/arb_memory_if.sv
// Per-port request/response bundle for arb_memory; err exists only with ARB_MEMORY_ERR_EN.
// Level requests held until the one-cycle resp pulse; no other backpressure.
interface arb_memory_if #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic [NUM_PORTS-1:0]                     read;
    logic [NUM_PORTS-1:0]                     write;
    logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]   byte_enable;
    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]     address;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     wdata;
    logic [NUM_PORTS-1:0]                     resp;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]     rdata;
`ifdef ARB_MEMORY_ERR_EN
    logic [NUM_PORTS-1:0]                     err;

    modport master (output read, write, byte_enable, address, wdata,
                    input  resp, rdata, err);
    modport slave  (input  read, write, byte_enable, address, wdata,
                    output resp, rdata, err);
`else
    modport master (output read, write, byte_enable, address, wdata,
                    input  resp, rdata);
    modport slave  (input  read, write, byte_enable, address, wdata,
                    output resp, rdata);
`endif
endinterface

// File: rtl/arb_memory_rr_arbiter.sv
// Round-robin pick: first requesting port at or after ptr, wrapping; one-hot and index out.
// Purely combinational, zero latency; requests not picked simply stay pending upstream.
module rr_arbiter
    import arb_memory_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    localparam int PW        = port_bits(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [PW-1:0]        gnt_idx,
    output logic                 found
);

    int cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = (int'(ptr) + i) % NUM_PORTS;
            if (!found && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/arb_memory.sv
// Multi-port round-robin word memory; optional range/conflict error reporting via ARB_MEMORY_ERR_EN.
// Latency: resp exactly LATENCY cycles after the grant cycle; one transaction per LATENCY+1 cycles.
// Backpressure: requests are levels held until resp; ungranted ports simply wait their turn.
module arb_memory
    import arb_memory_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 3
) (
    input  logic         clk,
    input  logic         rst,
    arb_memory_if.slave  bus
);

    localparam int LANES = lane_count(DATA_WIDTH);
    localparam int OFF   = offset_bits(DATA_WIDTH);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PW    = port_bits(NUM_PORTS);
    localparam int CW    = $clog2(LATENCY + 1);

    typedef struct packed {
        logic [PW-1:0] port;
        logic          is_read;
    } rec_t;

    state_e                              state_q, state_d;
    logic [CW-1:0]                       cnt_q, cnt_d;
    logic [PW-1:0]                       ptr_q, ptr_d;
    rec_t                                rec_q, rec_d;
    logic [NUM_PORTS-1:0]                req, gnt;
    logic [PW-1:0]                       gnt_idx;
    logic                                any_req, take, is_read_g, oor_g, mem_we;
    logic [IDX_W-1:0]                    widx;
    logic [DATA_WIDTH-1:0]               mem [DEPTH];
    logic [DATA_WIDTH-1:0]               hold_q, rd_word;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata_q;

    assign req = bus.read | bus.write;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .found   (any_req)
    );

    // Read wins when both read and write are raised on the granted port.
    assign is_read_g = |(gnt & bus.read);
    assign widx      = bus.address[gnt_idx][OFF +: IDX_W];
    assign take      = (state_q == IDLE) && any_req && !rst;

`ifdef ARB_MEMORY_ERR_EN
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(DEPTH * LANES);
    logic err_g, err_q;

    assign oor_g = {1'b0, bus.address[gnt_idx]} >= SPAN;
    assign err_g = oor_g | (|(gnt & bus.read & bus.write));
`else
    assign oor_g = 1'b0;
`endif

    assign mem_we  = take && !is_read_g && !oor_g;
    assign rd_word = oor_g ? '0 : mem[widx];

    // Array and read holding register are deliberately outside reset.
    always_ff @(posedge clk) begin
        if (take) hold_q <= rd_word;
        if (mem_we) begin
            for (int b = 0; b < LANES; b++) begin
                if (bus.byte_enable[gnt_idx][b]) mem[widx][b*8 +: 8] <= bus.wdata[gnt_idx][b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        rec_d   = rec_q;
        unique case (state_q)
            IDLE: if (take) begin
                rec_d.port    = gnt_idx;
                rec_d.is_read = is_read_g;
                ptr_d         = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
                if (LATENCY == 1) begin
                    state_d = RESP;
                end else begin
                    state_d = BUSY;
                    cnt_d   = CW'(LATENCY - 1);
                end
            end
            BUSY: if (cnt_q == CW'(1)) begin
                state_d = RESP;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q - 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            rec_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            rec_q   <= rec_d;
        end
    end

    // rdata_q keeps each port's last read word; the RESP cycle forwards hold_q directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (state_q == RESP && rec_q.is_read) begin
            rdata_q[rec_q.port] <= hold_q;
        end
    end

    always_comb begin
        bus.resp  = '0;
        bus.rdata = rdata_q;
        if (state_q == RESP) begin
            bus.resp[rec_q.port] = 1'b1;
            if (rec_q.is_read) bus.rdata[rec_q.port] = hold_q;
        end
    end

`ifdef ARB_MEMORY_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)       err_q <= 1'b0;
        else if (take) err_q <= err_g;
    end

    always_comb begin
        bus.err = '0;
        if (state_q == RESP && err_q) bus.err[rec_q.port] = 1'b1;
    end
`endif

endmodule

// File: tb/tb_arb_memory.sv
// Bench for arb_memory: directed scenarios plus random batches against a transaction-level model.
module tb_arb_memory;

    localparam int NP    = 2;
    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 256;
    localparam int LAT   = 3;

    logic clk = 1'b0;
    logic rst;

    arb_memory_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    arb_memory #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .LATENCY    (LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rd;
        bit        wr;
        bit [1:0]  be;
        bit [15:0] addr;
        bit [15:0] wd;
    } txn_t;

    txn_t      tx [NP][32];
    int        ntx [NP];
    bit [15:0] mem_m [DEPTH];
    bit [15:0] rdata_m [NP];
    int        ptr_m;
    int        sched_port [64];
    bit [15:0] sched_rd [64];
    bit        sched_err [64];
    bit        sched_isrd [64];
    int        checks = 0;
    int        errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input int p, input bit rd, input bit wr, input bit [1:0] be,
                       input bit [15:0] addr, input bit [15:0] wd);
        tx[p][ntx[p]] = '{rd: rd, wr: wr, be: be, addr: addr, wd: wd};
        ntx[p]++;
    endtask

    task automatic drive(input int p, input txn_t t);
        bus.read[p]        = t.rd;
        bus.write[p]       = t.wr;
        bus.byte_enable[p] = t.be;
        bus.address[p]     = t.addr;
        bus.wdata[p]       = t.wd;
    endtask

    task automatic idle_port(input int p);
        bus.read[p]  = 1'b0;
        bus.write[p] = 1'b0;
    endtask

    // Memory semantics at transaction level: word = byte address / 2, wrapping over DEPTH words.
    function automatic void model_apply(input txn_t t, output bit [15:0] rv, output bit er, output bit isrd);
        int idx;
        bit oor;
        idx  = (int'(t.addr) / 2) % DEPTH;
        isrd = t.rd;
`ifdef ARB_MEMORY_ERR_EN
        oor = int'(t.addr) >= DEPTH * 2;
        er  = oor || (t.rd && t.wr);
`else
        oor = 1'b0;
        er  = 1'b0;
`endif
        rv = 16'h0;
        if (t.rd) begin
            rv = oor ? 16'h0 : mem_m[idx];
        end else if (!oor) begin
            if (t.be[0]) mem_m[idx][7:0]  = t.wd[7:0];
            if (t.be[1]) mem_m[idx][15:8] = t.wd[15:8];
        end
    endfunction

    // Runs all queued transactions; each port re-requests right after its resp.
    task automatic run_batch();
        int head [NP];
        int total;
        int p;
        int last;
        int slot;
        bit [NP-1:0] exp_resp;
        bit [NP-1:0] exp_err;
        total = 0;
        for (int i = 0; i < NP; i++) begin
            head[i] = 0;
            total += ntx[i];
        end
        for (int k = 0; k < total; k++) begin
            p = -1;
            for (int i = 0; i < NP; i++) begin
                int c;
                c = (ptr_m + i) % NP;
                if (p < 0 && head[c] < ntx[c]) p = c;
            end
            model_apply(tx[p][head[p]], sched_rd[k], sched_err[k], sched_isrd[k]);
            sched_port[k] = p;
            head[p]++;
            ptr_m = (p + 1) % NP;
        end
        for (int i = 0; i < NP; i++) begin
            head[i] = 0;
            if (ntx[i] > 0) drive(i, tx[i][0]);
        end
        last = LAT + (LAT + 1) * (total - 1);
        for (int e = 1; e <= last + 1; e++) begin
            @(posedge clk);
            #1;
            exp_resp = '0;
            exp_err  = '0;
            if (e >= LAT && (e - LAT) % (LAT + 1) == 0) begin
                slot = (e - LAT) / (LAT + 1);
                if (slot < total) begin
                    exp_resp[sched_port[slot]] = 1'b1;
                    exp_err[sched_port[slot]]  = sched_err[slot];
                    if (sched_isrd[slot]) rdata_m[sched_port[slot]] = sched_rd[slot];
                end
            end
            for (int i = 0; i < NP; i++) begin
                chk($sformatf("resp%0d@%0d", i, e), 32'(bus.resp[i]), 32'(exp_resp[i]));
                chk($sformatf("rdata%0d@%0d", i, e), 32'(bus.rdata[i]), 32'(rdata_m[i]));
`ifdef ARB_MEMORY_ERR_EN
                chk($sformatf("err%0d@%0d", i, e), 32'(bus.err[i]), 32'(exp_err[i]));
`endif
            end
            for (int i = 0; i < NP; i++) begin
                if (exp_resp[i]) begin
                    head[i]++;
                    if (head[i] < ntx[i]) drive(i, tx[i][head[i]]);
                    else idle_port(i);
                end
            end
        end
        for (int i = 0; i < NP; i++) ntx[i] = 0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        for (int i = 0; i < NP; i++) idle_port(i);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("rst_resp%0d", i), 32'(bus.resp[i]), 32'h0);
            chk($sformatf("rst_rdata%0d", i), 32'(bus.rdata[i]), 32'h0);
            rdata_m[i] = 16'h0;
        end
        ptr_m = 0;
        rst   = 1'b0;
    endtask

    initial begin
        int n;
        bit rd;
        bit wr;
        bit [15:0] a;

        rst             = 1'b1;
        bus.read        = '0;
        bus.write       = '0;
        bus.byte_enable = '0;
        bus.address     = '0;
        bus.wdata       = '0;
        for (int i = 0; i < NP; i++) ntx[i] = 0;
        reset_dut();

        // Fill the words used by the random phase so every read has a known value.
        for (int w = 0; w < 16; w++) add(0, 1'b0, 1'b1, 2'b11, 16'(w * 2), 16'($urandom));
        run_batch();

        add(0, 1'b0, 1'b1, 2'b11, 16'h0010, 16'hBEEF);
        add(0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000);
        run_batch();
        chk("t1_rdata0", 32'(bus.rdata[0]), 32'hBEEF);

        add(1, 1'b0, 1'b1, 2'b01, 16'h0010, 16'h1234);
        run_batch();
        add(0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000);
        run_batch();
        chk("t2_rdata0", 32'(bus.rdata[0]), 32'hBE34);

        reset_dut();
        add(0, 1'b1, 1'b0, 2'b00, 16'h0010, 16'h0000);
        add(1, 1'b1, 1'b0, 2'b00, 16'h0004, 16'h0000);
        run_batch();

        for (int p = 0; p < NP; p++) begin
            for (int i = 0; i < 3; i++) add(p, 1'b1, 1'b0, 2'b00, 16'($urandom_range(0, 15) * 2), 16'h0);
        end
        run_batch();

        // Reset while the port0 read is in BUSY: that transaction must never respond.
        drive(0, '{rd: 1'b1, wr: 1'b0, be: 2'b00, addr: 16'h0010, wd: 16'h0});
        @(posedge clk);
        #1;
        chk("t5_resp0_busy", 32'(bus.resp[0]), 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("t5_resp%0d", i), 32'(bus.resp[i]), 32'h0);
            chk($sformatf("t5_rdata%0d", i), 32'(bus.rdata[i]), 32'h0);
            rdata_m[i] = 16'h0;
        end
        rst   = 1'b0;
        ptr_m = 0;
        idle_port(0);
        add(1, 1'b1, 1'b0, 2'b00, 16'h0004, 16'h0000);
        run_batch();

        add(0, 1'b0, 1'b1, 2'b11, 16'h0010, 16'hA5A5);
        add(0, 1'b1, 1'b0, 2'b00, 16'h0210, 16'h0000);
        run_batch();
`ifdef ARB_MEMORY_ERR_EN
        chk("t6_rdata0", 32'(bus.rdata[0]), 32'h0000);
`else
        chk("t6_rdata0", 32'(bus.rdata[0]), 32'hA5A5);
`endif

        for (int b = 0; b < 3; b++) begin
            for (int p = 0; p < NP; p++) begin
                n = $urandom_range(3, 7);
                for (int i = 0; i < n; i++) begin
                    rd = 1'($urandom_range(0, 1));
                    wr = !rd || ($urandom_range(0, 5) == 0);
                    a  = 16'($urandom_range(0, 15) * 2);
                    if ($urandom_range(0, 3) == 0) a = a | 16'h0200;
                    add(p, rd, wr, 2'($urandom_range(0, 3)), a, 16'($urandom));
                end
            end
            run_batch();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
